mul_ctrl: RTL and testbench

- EXE-stage sequencer for the RV32M multiply ops MUL, MULH, MULHSU and MULHU.
- Sits between the decode/EXE operand path and the unsigned shift-add multiplier (`mul`), directly upstream of it.
- Converts signed operands to magnitudes and drives the multiplier's level req / one-cycle ready handshake.
- Sign-corrects the 64-bit product, selects the low or high word, and stalls the pipeline until the result is available.
- Holds a one-entry operand/result cache so back-to-back ops on the same operands skip the multiplier.

---
 rtl/mul_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mul_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_ctrl.sv
// EXE-stage sequencer for RV32M MUL/MULH/MULHSU/MULHU in front of an unsigned
// shift-add multiplier, with a one-entry operand/product cache.
module mul_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      op_valid_i,
  input  logic [1:0]                op_i,
  input  logic [DATA_WIDTH-1:0]     rs1_i,
  input  logic [DATA_WIDTH-1:0]     rs2_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic                      result_valid_o,
  output logic [DATA_WIDTH-1:0]     result_o,
  output logic                      mul_req_o,
  output logic [DATA_WIDTH-1:0]     mul_a_o,
  output logic [DATA_WIDTH-1:0]     mul_b_o,
  input  logic                      mul_ready_i,
  input  logic [2*DATA_WIDTH-1:0]   mul_result_i
);

  localparam int W = DATA_WIDTH;
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  // Handshake: mul_req_o is a level held from issue until mul_ready_i (or an
  // abort); mul_ready_i is a one-cycle pulse honoured only in WAIT. The
  // pipeline side holds op_valid_i/operands until result_valid_o pulses.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state;

  logic             a_signed;
  logic             b_signed;
  logic             a_neg;
  logic             b_neg;
  logic [W-1:0]     mag_a;
  logic [W-1:0]     mag_b;
  logic             hit;
  logic             accept;
  logic [2*W-1:0]   prod_signed;
  logic [W-1:0]     hit_word;
  logic [W-1:0]     new_word;

  logic             neg_q;
  logic [1:0]       op_q;
  logic [W-1:0]     rs1_q;
  logic [W-1:0]     rs2_q;
  logic             a_signed_q;
  logic             b_signed_q;

  logic             cache_valid;
  logic [W-1:0]     cache_rs1;
  logic [W-1:0]     cache_rs2;
  logic             cache_a_signed;
  logic             cache_b_signed;
  logic [2*W-1:0]   cache_p;

  always_comb begin
    a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU);
    b_signed = (op_i == OP_MULH);
    a_neg    = a_signed & rs1_i[W-1];
    b_neg    = b_signed & rs2_i[W-1];
    // The most negative value maps onto itself, which is still the right
    // unsigned magnitude.
    mag_a    = a_neg ? (-rs1_i) : rs1_i;
    mag_b    = b_neg ? (-rs2_i) : rs2_i;
  end

  // The low word of a product does not depend on operand signedness, so MUL
  // may reuse an entry produced by any of the high-word ops.
  always_comb begin
    hit = cache_valid
          && (rs1_i == cache_rs1)
          && (rs2_i == cache_rs2)
          && ((op_i == OP_MUL)
              || ((a_signed == cache_a_signed) && (b_signed == cache_b_signed)));
  end

  always_comb begin
    accept      = op_valid_i & ~flush_i & ~result_valid_o;
    prod_signed = neg_q ? (-mul_result_i) : mul_result_i;
    hit_word    = (op_i == OP_MUL) ? cache_p[W-1:0] : cache_p[2*W-1:W];
    new_word    = (op_q == OP_MUL) ? prod_signed[W-1:0] : prod_signed[2*W-1:W];
  end

  // Reset is folded in so the hold drops immediately on an asynchronous reset.
  assign stall_o = rst_i & op_valid_i & ~result_valid_o & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      result_valid_o <= 1'b0;
      result_o       <= '0;
      mul_req_o      <= 1'b0;
      mul_a_o        <= '0;
      mul_b_o        <= '0;
      neg_q          <= 1'b0;
      op_q           <= 2'b00;
      rs1_q          <= '0;
      rs2_q          <= '0;
      a_signed_q     <= 1'b0;
      b_signed_q     <= 1'b0;
      cache_valid    <= 1'b0;
      cache_rs1      <= '0;
      cache_rs2      <= '0;
      cache_a_signed <= 1'b0;
      cache_b_signed <= 1'b0;
      cache_p        <= '0;
    end else begin
      result_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (hit) begin
              result_o       <= hit_word;
              result_valid_o <= 1'b1;
              state          <= DONE;
            end else begin
              mul_a_o    <= mag_a;
              mul_b_o    <= mag_b;
              neg_q      <= a_neg ^ b_neg;
              op_q       <= op_i;
              rs1_q      <= rs1_i;
              rs2_q      <= rs2_i;
              a_signed_q <= a_signed;
              b_signed_q <= b_signed;
              mul_req_o  <= 1'b1;
              state      <= WAIT;
            end
          end
        end
        WAIT: begin
          // Dropping req aborts the multiplier; a coincident ready is lost.
          if (flush_i) begin
            mul_req_o <= 1'b0;
            state     <= IDLE;
          end else if (mul_ready_i) begin
            cache_valid    <= 1'b1;
            cache_rs1      <= rs1_q;
            cache_rs2      <= rs2_q;
            cache_a_signed <= a_signed_q;
            cache_b_signed <= b_signed_q;
            cache_p        <= prod_signed;
            result_o       <= new_word;
            result_valid_o <= 1'b1;
            mul_req_o      <= 1'b0;
            state          <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a behavioural multiplier of adjustable
// latency; expected results are hand-computed constants.
module tb_mul_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        op_valid_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        flush_i;
  logic        stall_o;
  logic        result_valid_o;
  logic [31:0] result_o;
  logic        mul_req_o;
  logic [31:0] mul_a_o;
  logic [31:0] mul_b_o;
  logic        mul_ready_i;
  logic [63:0] mul_result_i;

  int n_tests = 0;
  int n_fail  = 0;
  int mul_lat = 3;
  int cnt     = 0;
  logic stray = 1'b0;

  mul_ctrl #(.DATA_WIDTH(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .op_valid_i     (op_valid_i),
    .op_i           (op_i),
    .rs1_i          (rs1_i),
    .rs2_i          (rs2_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .mul_req_o      (mul_req_o),
    .mul_a_o        (mul_a_o),
    .mul_b_o        (mul_b_o),
    .mul_ready_i    (mul_ready_i),
    .mul_result_i   (mul_result_i)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Multiplier stand-in: ready pulses mul_lat cycles after req rises.
  always @(negedge clk_i) begin
    mul_ready_i = stray;
    if (!mul_req_o) begin
      cnt = 0;
    end else begin
      cnt++;
      if (cnt == mul_lat) begin
        mul_ready_i  = 1'b1;
        mul_result_i = {32'h0, mul_a_o} * {32'h0, mul_b_o};
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic exp_miss,
                        input logic [31:0] exp_ma, input logic [31:0] exp_mb);
    int edges;
    int rv_edge;
    int ready_edge;
    logic saw_req;
    logic stall_ok;
    logic [31:0] seen_a;
    logic [31:0] seen_b;
    @(negedge clk_i);
    op_valid_i = 1'b1;
    op_i       = op;
    rs1_i      = a;
    rs2_i      = b;
    #1;
    check({tag, "_stall_issue"}, stall_o, 1);
    check({tag, "_req_gap"}, mul_req_o, 0);
    edges = 0; rv_edge = -1; ready_edge = -1;
    saw_req = 1'b0; stall_ok = 1'b1; seen_a = '0; seen_b = '0;
    while (rv_edge < 0 && edges < 100) begin
      @(posedge clk_i);
      edges++;
      if (mul_ready_i) ready_edge = edges;
      #1;
      if (mul_req_o) begin
        saw_req = 1'b1;
        seen_a  = mul_a_o;
        seen_b  = mul_b_o;
      end
      if (result_valid_o) rv_edge = edges;
      else if (!stall_o) stall_ok = 1'b0;
    end
    check({tag, "_timeout"}, rv_edge >= 0, 1);
    check({tag, "_stall_hold"}, stall_ok, 1);
    check({tag, "_result"}, result_o, exp);
    check({tag, "_stall_done"}, stall_o, 0);
    check({tag, "_used_mul"}, saw_req, exp_miss);
    if (exp_miss) begin
      check({tag, "_mag_a"}, seen_a, exp_ma);
      check({tag, "_mag_b"}, seen_b, exp_mb);
      // valid is registered on the edge that samples ready
      check({tag, "_miss_lat"}, rv_edge, ready_edge);
    end else begin
      // issue cycle, then the DONE cycle
      check({tag, "_hit_lat"}, rv_edge, 1);
    end
    @(negedge clk_i);
    op_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check({tag, "_pulse"}, result_valid_o, 0);
  endtask

  initial begin
    int rv_count;
    rst_i = 1'b0; op_valid_i = 1'b0; op_i = 2'b00;
    rs1_i = '0; rs2_i = '0; flush_i = 1'b0;
    mul_ready_i = 1'b0; mul_result_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_req", mul_req_o, 0);
    check("rst_valid", result_valid_o, 0);
    check("rst_result", result_o, 0);
    check("rst_a", mul_a_o, 0);
    check("rst_b", mul_b_o, 0);
    check("rst_stall", stall_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // main directed vectors
    mul_lat = 3;
    run_op("mulhu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1, 32'h8000_0000, 32'h8000_0000);
    run_op("mulh_m1x7", 2'b01, 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 32'h0000_0007);
    run_op("mulhsu", 2'b10, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 32'h0000_0002, 32'hFFFF_FFFF);
    run_op("mul_hit", 2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0, 32'h0);
    run_op("mulhu_pair", 2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    mul_lat = 1;
    run_op("mul_zero", 2'b00, 32'h0, 32'h0000_1234, 32'h0, 1'b1, 32'h0, 32'h0000_1234);
    run_op("mul_zero_hit", 2'b00, 32'h0, 32'h0000_1234, 32'h0, 1'b0, 32'h0, 32'h0);

    // ready outside WAIT
    @(posedge clk_i);
    stray = 1'b1;
    @(posedge clk_i);
    stray = 1'b0;
    #1;
    check("stray_valid", result_valid_o, 0);
    check("stray_req", mul_req_o, 0);

    // flush mid-WAIT
    mul_lat = 6;
    @(negedge clk_i);
    op_valid_i = 1'b1; op_i = 2'b00; rs1_i = 32'd3; rs2_i = 32'd5;
    repeat (2) @(posedge clk_i);
    #1;
    check("flush_req_before", mul_req_o, 1);
    @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    check("flush_stall", stall_o, 0);
    @(posedge clk_i);
    #1;
    check("flush_req_after", mul_req_o, 0);
    @(negedge clk_i);
    flush_i = 1'b0; op_valid_i = 1'b0;
    rv_count = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i);
      #1;
      if (result_valid_o) rv_count++;
    end
    check("flush_no_valid", rv_count, 0);
    mul_lat = 3;
    run_op("flush_cache_kept", 2'b00, 32'h0, 32'h0000_1234, 32'h0, 1'b0, 32'h0, 32'h0);
    run_op("reissue_3x5", 2'b00, 32'd3, 32'd5, 32'd15, 1'b1, 32'd3, 32'd5);

    // asynchronous reset mid-WAIT clears the cache
    run_op("mul_6x7", 2'b00, 32'd6, 32'd7, 32'd42, 1'b1, 32'd6, 32'd7);
    mul_lat = 8;
    @(negedge clk_i);
    op_valid_i = 1'b1; op_i = 2'b11; rs1_i = 32'd9; rs2_i = 32'd9;
    repeat (2) @(posedge clk_i);
    #2;
    check("arst_req_before", mul_req_o, 1);
    rst_i = 1'b0;
    #1;
    check("arst_req", mul_req_o, 0);
    check("arst_stall", stall_o, 0);
    check("arst_valid", result_valid_o, 0);
    @(negedge clk_i);
    op_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    mul_lat = 3;
    run_op("post_rst_6x7", 2'b00, 32'd6, 32'd7, 32'd42, 1'b1, 32'd6, 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
